// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: entry layout and default FIFO geometry.
package uart_pkg;
  localparam int DATA_W    = 9;
  localparam int ENTRY_W   = 11;
  localparam int DATA_LSB  = 0;
  localparam int DATA_MSB  = 8;
  localparam int FERR_BIT  = 9;
  localparam int PERR_BIT  = 10;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = 4;

  // Field order matches the bit positions above (perr is the MSB).
  typedef struct packed {
    logic              perr;
    logic              ferr;
    logic [DATA_W-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with separate level counter; shared by RX and TX paths.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 11
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic [AW:0]  o_level,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   level;
  logic          do_push;
  logic          do_pop;

  assign o_empty = (level == '0);
  assign o_full  = (level == (AW+1)'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = i_push && (!o_full || do_pop);

  // NOTE: the storage array has no reset; level/pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem[wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign o_rdata = mem[rd_ptr];
  assign o_level = level;
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO front-end: captures uart_rx frames on busy falling edge, clears its sticky errors, raises level irq.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_busy,
  input  logic              i_rx_parity_err,
  input  logic              i_rx_overrun_err,
  output logic              o_rx_rst_err,
  input  logic              i_rd,
  input  logic              i_flush,
  input  logic              i_clr_ovf,
  input  logic [AW:0]       i_thresh,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_perr,
  output logic              o_rd_ferr,
  output logic              o_empty,
  output logic              o_full,
  output logic [AW:0]       o_level,
  output logic              o_ovf,
  output logic              o_irq
);
  logic               busy_q;
  logic               cap;
  logic               drop;
  rx_entry_t          wr_entry;
  logic [ENTRY_W-1:0] head;

  assign cap      = busy_q && !i_rx_busy;
  // A full FIFO only drops if no pop frees a slot this cycle; flush swallows the frame silently.
  assign drop     = cap && o_full && !i_rd && !i_flush;
  assign wr_entry = '{perr: i_rx_parity_err, ferr: i_rx_overrun_err, data: i_rx_data};

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (cap),
    .i_pop   (i_rd),
    .i_flush (i_flush),
    .i_wdata (wr_entry),
    .o_rdata (head),
    .o_level (o_level),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  assign o_rd_data = head[DATA_MSB:DATA_LSB];
  assign o_rd_ferr = head[FERR_BIT];
  assign o_rd_perr = head[PERR_BIT];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q       <= 1'b0;
      o_rx_rst_err <= 1'b0;
      o_ovf        <= 1'b0;
      o_irq        <= 1'b0;
    end else begin
      busy_q       <= i_rx_busy;
      o_rx_rst_err <= cap;
      if (drop)           o_ovf <= 1'b1;
      else if (i_clr_ovf) o_ovf <= 1'b0;
      o_irq        <= (i_thresh != '0) && (o_level >= i_thresh);
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH 16).
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] rx_data;
  logic       rx_busy;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rx_rst_err;
  logic       rd;
  logic       flush;
  logic       clr_ovf;
  logic [4:0] thresh;
  logic [8:0] rd_data;
  logic       rd_perr;
  logic       rd_ferr;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       ovf;
  logic       irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_rx_data        (rx_data),
    .i_rx_busy        (rx_busy),
    .i_rx_parity_err  (rx_perr),
    .i_rx_overrun_err (rx_ferr),
    .o_rx_rst_err     (rx_rst_err),
    .i_rd             (rd),
    .i_flush          (flush),
    .i_clr_ovf        (clr_ovf),
    .i_thresh         (thresh),
    .o_rd_data        (rd_data),
    .o_rd_perr        (rd_perr),
    .o_rd_ferr        (rd_ferr),
    .o_empty          (empty),
    .o_full           (full),
    .o_level          (level),
    .o_ovf            (ovf),
    .o_irq            (irq)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: busy high for a cycle, then low with data valid (cap cycle); returns just after the capture edge.
  task automatic frame(input logic [8:0] d, input logic pe, input logic fe, input logic rd_same);
    rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0;
    rx_data = d;
    rx_perr = pe;
    rx_ferr = fe;
    rd      = rd_same;
    tick();
    rd      = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_rst_err"}, rx_rst_err, 0);
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_busy = 1'b0; rx_perr = 1'b0; rx_ferr = 1'b0;
    rd = 1'b0; flush = 1'b0; clr_ovf = 1'b0; thresh = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Two clean frames, one rst_err pulse each, FWFT order.
    frame(9'h055, 0, 0, 0);
    check("f1_rst_err", rx_rst_err, 1);
    check("f1_empty", empty, 0);
    check("f1_head", rd_data, 'h055);
    tick();
    check("f1_rst_err_end", rx_rst_err, 0);
    frame(9'h1A3, 0, 0, 0);
    check("f2_rst_err", rx_rst_err, 1);
    tick();
    check("f2_rst_err_end", rx_rst_err, 0);
    check("two_level", level, 2);
    check("two_head0", rd_data, 'h055);
    pop();
    check("two_head1", rd_data, 'h1A3);
    check("two_level1", level, 1);
    pop();
    check("two_empty", empty, 1);

    // Error flags travel with their entry.
    frame(9'h0FF, 1, 0, 0);
    check("perr_data", rd_data, 'h0FF);
    check("perr_flag", rd_perr, 1);
    check("perr_ferr", rd_ferr, 0);
    frame(9'h001, 0, 0, 0);
    pop();
    check("clean_data", rd_data, 'h001);
    check("clean_perr", rd_perr, 0);
    pop();
    check("err_empty", empty, 1);

    // Fill to 16, 17th frame dropped.
    for (int i = 1; i <= 16; i++) frame(9'(i), 0, 0, 0);
    check("fill_full", full, 1);
    check("fill_ovf0", ovf, 0);
    frame(9'd17, 0, 0, 0);
    check("drop_ovf", ovf, 1);
    check("drop_level", level, 16);
    check("drop_head", rd_data, 1);
    check("drop_rst_err", rx_rst_err, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf", ovf, 0);

    // Full with simultaneous cap and read.
    frame(9'h155, 0, 0, 1);
    check("fullrw_level", level, 16);
    check("fullrw_ovf", ovf, 0);
    check("fullrw_head", rd_data, 2);
    for (int i = 0; i < 15; i++) pop();
    check("fullrw_tail", rd_data, 'h155);
    check("fullrw_lvl1", level, 1);
    pop();
    pop();
    check("rd_empty_lvl", level, 0);
    check("rd_empty_flag", empty, 1);

    // Empty with simultaneous cap and read.
    frame(9'h0AA, 0, 1, 1);
    check("emptyrw_level", level, 1);
    check("emptyrw_head", rd_data, 'h0AA);
    check("emptyrw_ferr", rd_ferr, 1);
    pop();

    // Threshold interrupt.
    thresh = 5'd4;
    for (int i = 0; i < 4; i++) frame(9'(8'h40 + i), 0, 0, 0);
    check("irq_level4", level, 4);
    check("irq_lag", irq, 0);
    tick();
    check("irq_set", irq, 1);
    pop();
    check("irq_hold", irq, 1);
    tick();
    check("irq_clr", irq, 0);
    thresh = 5'd0;
    frame(9'h050, 0, 0, 0);
    frame(9'h051, 0, 0, 0);
    tick();
    check("irq_thr0", irq, 0);
    check("lvl5", level, 5);

    // Flush with simultaneous cap.
    rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0;
    rx_data = 9'h123;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    check("flush_rst_err", rx_rst_err, 1);
    tick();
    check("flush_rst_err_end", rx_rst_err, 0);

    // Reset mid-frame while full, overflowed and interrupting.
    thresh = 5'd4;
    for (int i = 0; i < 17; i++) frame(9'(i), 0, 0, 0);
    tick();
    check("pre_rst_ovf", ovf, 1);
    check("pre_rst_irq", irq, 1);
    rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    check_reset_state("midrst");
    tick();
    check("postrst_rst_err", rx_rst_err, 0);
    check("postrst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
